if_fetch_queue: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of the ID stage.

---
 rtl/if_pkg.sv | 11 +
 rtl/if_sync_fifo.sv | 56 +++++
 rtl/if_fetch_queue.sv | 130 +++++++++++++
 tb/tb_if_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage widths, reset PC default and the buffered fetch entry type.
package if_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/if_sync_fifo.sv
// Flushable FIFO of fetch entries, head read from registered storage: push-to-head 1 cycle.
// Backpressure is the caller's job; a push into a full FIFO without a pop is illegal.
module if_sync_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   output fetch_entry_t           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop) count <= count + (AW+1)'(1);
         else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
   end

   // The upstream issue rule reserves a slot for every in-flight fetch.
   ovf_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the PC, issues imem requests, buffers in-order responses; accept-to-id_valid = mem latency + 1.
// Issue throttled by FIFO slots + in-flight count and MAX_OUTST; IF_PERF_CNT_EN adds perf counters.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int              DEPTH     = 2,
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [1:0]  outst_cnt
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc, fetch_pc_nxt;
   logic [31:0]   resp_pc, resp_pc_nxt;
   logic [31:0]   target;
   logic [CW-1:0] outst, outst_nxt;
   logic [CW-1:0] drop, drop_nxt;
   logic [CW-1:0] fifo_count;
   logic          req_fire, rsp_take;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;

   assign target = {redirect_pc[31:2], 2'b00};

   // Buffered + in-flight never exceeds DEPTH, so a response always finds a slot.
   assign imem_req_valid = rst_n && !redirect_valid && !fifo_full
                        && (32'(fifo_count) + 32'(outst) < 32'(DEPTH))
                        && (32'(outst) < 32'(MAX_OUTST));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Nothing in flight means any response is a leftover from before reset.
   assign rsp_take  = imem_rsp_valid && (outst != '0);
   assign fifo_pop  = id_valid && id_ready && !redirect_valid;
   assign outst_cnt = outst[1:0];

   assign push_entry.pc    = resp_pc;
   assign push_entry.instr = imem_rsp_data;

   assign id_valid = !fifo_empty;
   assign id_pc    = fifo_head.pc;
   assign id_instr = fifo_head.instr;

   always_comb begin
      fetch_pc_nxt = fetch_pc;
      resp_pc_nxt  = resp_pc;
      outst_nxt    = outst;
      drop_nxt     = drop;
      fifo_push    = 1'b0;
      if (req_fire) fetch_pc_nxt = fetch_pc + 32'd4;
      if (req_fire && !rsp_take) outst_nxt = outst + CW'(1);
      else if (!req_fire && rsp_take) outst_nxt = outst - CW'(1);
      if (redirect_valid) begin
         fetch_pc_nxt = target;
         resp_pc_nxt  = target;
         drop_nxt     = outst - CW'(rsp_take);
      end else if (rsp_take) begin
         if (drop != '0) begin
            drop_nxt = drop - CW'(1);
         end else begin
            fifo_push   = 1'b1;
            resp_pc_nxt = resp_pc + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         outst    <= '0;
         drop     <= '0;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         resp_pc  <= resp_pc_nxt;
         outst    <= outst_nxt;
         drop     <= drop_nxt;
      end
   end

   if_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (req_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (rsp_take && (redirect_valid || drop != '0)) perf_drop_cnt <= perf_drop_cnt + 32'd1;
         if (id_ready && !id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model plus a PC-stream scoreboard.
module tb_if_fetch_queue;
   localparam int          DEPTH     = 2;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  outst_cnt;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .outst_cnt      (outst_cnt)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_drop_cnt  (perf_drop_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          pops = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          m_fetch, m_drop, m_stall;
   logic [31:0] exp_req_addr, exp_id_pc, last_pop_pc;
   logic [31:0] fl_addr[$];
   int          fl_due[$];
   bit          fl_stale[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   function automatic bit due_now();
      return (fl_addr.size() != 0) && (fl_due[0] <= cyc);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fl_addr.delete();
      fl_due.delete();
      fl_stale.delete();
      exp_req_addr = RESET_PC;
      exp_id_pc    = RESET_PC;
      m_fetch = 0;
      m_drop  = 0;
      m_stall = 0;
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input bit mrdy, input bit idr, input bit redir, input logic [31:0] tgt, input bit stray);
      bit rsp, fire, pop;
      rsp = due_now();
      imem_req_ready = mrdy;
      id_ready       = idr;
      redirect_valid = redir;
      redirect_pc    = tgt;
      imem_rsp_valid = rsp || stray;
      imem_rsp_data  = 32'hBAD0_BAD0;
      if (rsp) imem_rsp_data = mem_word(fl_addr[0]);
      #1;
      chk("outst", 32'(outst_cnt), 32'(fl_addr.size()));
      if (redir) chk("req_vld_on_redirect", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) begin
         chk("req_addr", imem_req_addr, exp_req_addr);
         chk("req_cap", 32'(fl_addr.size() < MAX_OUTST), 32'd1);
      end
      fire = imem_req_valid && mrdy;
      pop  = id_valid && idr && !redir;
      if (pop) begin
         chk("id_pc", id_pc, exp_id_pc);
         chk("id_instr", id_instr, mem_word(exp_id_pc));
         last_pop_pc = id_pc;
         exp_id_pc   = exp_id_pc + 32'd4;
         pops++;
      end
      if (idr && !id_valid) m_stall++;
      if (rsp) begin
         if (fl_stale[0] || redir) m_drop++;
         void'(fl_addr.pop_front());
         void'(fl_due.pop_front());
         void'(fl_stale.pop_front());
      end
      if (fire) begin
         fl_addr.push_back(exp_req_addr);
         fl_due.push_back(cyc + $urandom_range(lat_max, lat_min));
         fl_stale.push_back(1'b0);
         exp_req_addr = exp_req_addr + 32'd4;
         m_fetch++;
      end
      if (redir) begin
         foreach (fl_stale[i]) fl_stale[i] = 1'b1;
         exp_req_addr = {tgt[31:2], 2'b00};
         exp_id_pc    = exp_req_addr;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_until_pop(input string tag, input logic [31:0] exp, input int bound);
      int  p0;
      bit  found;
      p0    = pops;
      found = 1'b0;
      for (int i = 0; i < bound && !found; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
         if (pops != p0) found = 1'b1;
      end
      chk({tag, "_seen"}, 32'(found), 32'd1);
      if (found) chk(tag, last_pop_pc, exp);
   endtask

   initial begin
      int  p0;
      bit  hit;
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
      chk("rst_id_vld", 32'(id_valid), 32'd0);
      chk("rst_outst", 32'(outst_cnt), 32'd0);
      rst_n = 1'b1;

      // Zero-wait memory: first pair two cycles after the first acceptance.
      chk("t1_vld_c0", 32'(id_valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      chk("t1_vld_c1", 32'(id_valid), 32'd0);
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      chk("t1_vld_c2", 32'(id_valid), 32'd1);
      chk("t1_pc_c2", id_pc, RESET_PC);
      repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

      // ID stalled: FIFO fills, requests stop, then exactly DEPTH entries drain.
      repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t2_req_vld", 32'(imem_req_valid), 32'd0);
      chk("t2_id_vld", 32'(id_valid), 32'd1);
      chk("t2_outst", 32'(outst_cnt), 32'd0);
      p0 = pops;
      for (int i = 0; i < 8 && id_valid; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      chk("t2_buffered", 32'(pops - p0), 32'(DEPTH));
      repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

      // Latency 3, two requests in flight, redirect to an unaligned target.
      lat_min = 3;
      lat_max = 3;
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         if (outst_cnt == 2'd2 && !due_now()) hit = 1'b1;
         else cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      end
      chk("t3_two_inflight", 32'(hit), 32'd1);
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
      run_until_pop("t3_first_pc", 32'h0000_0100, 40);

      // Redirect coinciding with a response and an ID pop.
      lat_min = 1;
      lat_max = 1;
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
         if (id_valid && due_now()) hit = 1'b1;
         else cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      end
      chk("t4_setup", 32'(hit), 32'd1);
      p0 = fl_addr.size();
      cycle(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b0);
      chk("t4_fifo_empty", 32'(id_valid), 32'd0);
      chk("t4_outst_minus_rsp", 32'(outst_cnt), 32'(p0 - 1));
      run_until_pop("t4_first_pc", 32'h0000_0500, 20);

      // Wrap at the top of the address space.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
      run_until_pop("t5_pc0", 32'hFFFF_FFF8, 20);
      run_until_pop("t5_pc1", 32'hFFFF_FFFC, 20);
      run_until_pop("t5_pc2", 32'h0000_0000, 20);

      // Randomized traffic, latency, backpressure and redirects.
      lat_min = 1;
      lat_max = 4;
      repeat (1500)
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 24) == 0, $urandom(), 1'b0);

      // Async reset with a response pending; a late response must be ignored.
      lat_min = 3;
      lat_max = 3;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (outst_cnt != 2'd0) hit = 1'b1;
         else cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      end
      chk("t6_pending", 32'(hit), 32'd1);
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req_vld_async", 32'(imem_req_valid), 32'd0);
      chk("t6_id_vld_async", 32'(id_valid), 32'd0);
      chk("t6_outst_async", 32'(outst_cnt), 32'd0);
      model_reset();
`ifdef IF_PERF_CNT_EN
      chk("t6_perf_fetch_rst", perf_fetch_cnt, 32'd0);
      chk("t6_perf_drop_rst", perf_drop_cnt, 32'd0);
      chk("t6_perf_stall_rst", perf_stall_cnt, 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      run_until_pop("t6_restart_pc", RESET_PC, 20);
      repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
      chk("perf_drop", perf_drop_cnt, 32'(m_drop));
      chk("perf_stall", perf_stall_cnt, 32'(m_stall));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
